// File: rtl/cpc_rst_pkg.sv
// Shared types and constants for the CPC PLL reset/lock supervisor.
// Holds the FSM state encoding, stage indices and small arithmetic helpers.
package cpc_rst_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLDOFF   = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  localparam int NUM_STAGES = 4;

  // Stage k feeds the domain clocked from the k-th PLL output.
  localparam int STAGE_48M = 0;
  localparam int STAGE_16M = 1;
  localparam int STAGE_4M  = 2;
  localparam int STAGE_1M  = 3;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'h01;
    end
  endfunction

endpackage

// File: rtl/cpc_rst_seq_if.sv
// Bundle of PLL-side and domain-reset signals around the reset supervisor.
// master = supervisor, slave = PLL and reset-domain environment.
interface cpc_rst_seq_if;
  import cpc_rst_pkg::*;

  logic                  pll_locked;
  logic                  force_relock;
  logic                  pll_rst;
  logic [NUM_STAGES-1:0] sys_rst_n;
  logic                  ready;
  logic [7:0]            relock_cnt;
  logic                  lock_fail;

  modport master (
    input  pll_locked, force_relock,
    output pll_rst, sys_rst_n, ready, relock_cnt, lock_fail
  );

  modport slave (
    output pll_locked, force_relock,
    input  pll_rst, sys_rst_n, ready, relock_cnt, lock_fail
  );

endinterface

// File: rtl/cpc_sync2.sv
// Generic two-flop synchronizer for bringing asynchronous levels into a clock domain.
module cpc_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two back-to-back flops give metastability time to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/cpc_rst_seq.sv
// Reset/lock supervisor: pulses the PLL reset, waits for stable lock, then
// releases the domain resets in order; any lock loss or forced relock restarts it.
module cpc_rst_seq
  import cpc_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int HOLDOFF_CYCLES = 1024,
  parameter int STAGE_GAP      = 64,
  parameter int MAX_RETRIES    = 8
) (
  input logic           refclk,
  input logic           rst_n,
  cpc_rst_seq_if.master bus
);

  localparam int CNT_MAX = max_int(max_int(LOCK_TIMEOUT, HOLDOFF_CYCLES),
                                   max_int(3 * STAGE_GAP + 1, PLL_RST_CYCLES));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTRY_W  = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]  PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RELEASE_LAST = CNT_W'(STAGE_1M * STAGE_GAP);
  localparam logic [RTRY_W-1:0] RETRY_MAX    = RTRY_W'(MAX_RETRIES);

  state_e                state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [RTRY_W-1:0]     retry_r;
  logic [RTRY_W-1:0]     retry_inc_s;
  logic                  locked_s;
  logic                  abort_s;
  logic                  pll_rst_r;
  logic [NUM_STAGES-1:0] sys_rst_n_r;
  logic                  ready_r;
  logic [7:0]            relock_cnt_r;
  logic                  lock_fail_r;

  cpc_sync2 #(.WIDTH(1)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (bus.pll_locked),
    .q     (locked_s)
  );

  // Saturating next value of the consecutive-timeout counter.
  always_comb begin
    retry_inc_s = retry_r;
    if (retry_r == RETRY_MAX) begin
      retry_inc_s = retry_r;
    end else begin
      retry_inc_s = retry_r + RTRY_W'(1);
    end
  end

  // Lock loss wins over a simultaneous forced relock for the relock count.
  always_comb begin
    abort_s = 1'b0;
    if (!locked_s || bus.force_relock) begin
      abort_s = 1'b1;
    end else begin
      abort_s = 1'b0;
    end
  end

  // Supervisor FSM with shared cycle counter and registered outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_PLL_RST;
      cnt_r        <= '0;
      retry_r      <= '0;
      pll_rst_r    <= 1'b1;
      sys_rst_n_r  <= '0;
      ready_r      <= 1'b0;
      relock_cnt_r <= 8'h00;
      lock_fail_r  <= 1'b0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      case (state_r)
        ST_PLL_RST: begin
          pll_rst_r <= 1'b1;
          if (cnt_r == PLL_RST_LAST) begin
            state_r   <= ST_WAIT_LOCK;
            cnt_r     <= '0;
            pll_rst_r <= 1'b0;
          end
        end
        ST_WAIT_LOCK: begin
          pll_rst_r <= 1'b0;
          if (locked_s) begin
            state_r <= ST_HOLDOFF;
            cnt_r   <= '0;
          end else if (cnt_r == TIMEOUT_LAST) begin
            state_r   <= ST_PLL_RST;
            cnt_r     <= '0;
            pll_rst_r <= 1'b1;
            retry_r   <= retry_inc_s;
            if (retry_inc_s == RETRY_MAX) begin
              lock_fail_r <= 1'b1;
            end
          end
        end
        ST_HOLDOFF: begin
          if (!locked_s) begin
            state_r <= ST_WAIT_LOCK;
            cnt_r   <= '0;
          end else if (cnt_r == HOLDOFF_LAST) begin
            state_r <= ST_RELEASE;
            cnt_r   <= '0;
          end
        end
        ST_RELEASE, ST_RUN: begin
          if (abort_s) begin
            state_r     <= ST_PLL_RST;
            cnt_r       <= '0;
            pll_rst_r   <= 1'b1;
            sys_rst_n_r <= '0;
            ready_r     <= 1'b0;
            if (!locked_s) begin
              relock_cnt_r <= sat_inc8(relock_cnt_r);
            end
          end else if (state_r == ST_RELEASE) begin
            // Counter only climbs, so stages can only come out of reset in order.
            for (int k = 0; k < NUM_STAGES; k++) begin
              if (cnt_r == CNT_W'(k * STAGE_GAP)) begin
                sys_rst_n_r[k] <= 1'b1;
              end
            end
            if (cnt_r == RELEASE_LAST) begin
              state_r <= ST_RUN;
              cnt_r   <= '0;
              retry_r <= '0;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_PLL_RST;
          cnt_r       <= '0;
          pll_rst_r   <= 1'b1;
          sys_rst_n_r <= '0;
          ready_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_rst    = pll_rst_r;
  assign bus.sys_rst_n  = sys_rst_n_r;
  assign bus.ready      = ready_r;
  assign bus.relock_cnt = relock_cnt_r;
  assign bus.lock_fail  = lock_fail_r;

endmodule

// File: tb/tb_cpc_rst_seq.sv
// Directed bench for cpc_rst_seq with short timing parameters.
// Each task drives one scenario and checks hand-computed cycle-exact values.
module tb_cpc_rst_seq;

  logic refclk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cyc;

  cpc_rst_seq_if bus ();

  cpc_rst_seq #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (20),
    .HOLDOFF_CYCLES (8),
    .STAGE_GAP      (2),
    .MAX_RETRIES    (3)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Edge numbers below count rising edges after rst_n release.
  task automatic apply_reset(input logic lock);
    rst_n            = 1'b0;
    bus.pll_locked   = lock;
    bus.force_relock = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus.pll_locked   = 1'b1;
    bus.force_relock = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    vectors += 5;
    if (bus.pll_rst !== 1'b1) begin miscompares++; $display("FAIL reset_pll_rst got=%b exp=1", bus.pll_rst); end
    if (bus.sys_rst_n !== 4'b0000) begin miscompares++; $display("FAIL reset_sys_rst_n got=%b exp=0000", bus.sys_rst_n); end
    if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
    if (bus.relock_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_relock_cnt got=%0d exp=0", bus.relock_cnt); end
    if (bus.lock_fail !== 1'b0) begin miscompares++; $display("FAIL reset_lock_fail got=%b exp=0", bus.lock_fail); end
  endtask

  task automatic test_clean_start();
    logic [3:0] exp_sys;
    logic       exp_pll;
    logic       exp_rdy;
    apply_reset(1'b1);
    for (int e = 1; e <= 22; e++) begin
      tick();
      exp_pll = (e < 4);
      exp_sys = (e >= 20) ? 4'b1111 : (e >= 18) ? 4'b0111 :
                (e >= 16) ? 4'b0011 : (e >= 14) ? 4'b0001 : 4'b0000;
      exp_rdy = (e >= 21);
      vectors += 3;
      if (bus.pll_rst !== exp_pll) begin miscompares++; $display("FAIL clean_pll_rst cyc=%0d got=%b exp=%b", cyc, bus.pll_rst, exp_pll); end
      if (bus.sys_rst_n !== exp_sys) begin miscompares++; $display("FAIL clean_sys_rst_n cyc=%0d got=%b exp=%b", cyc, bus.sys_rst_n, exp_sys); end
      if (bus.ready !== exp_rdy) begin miscompares++; $display("FAIL clean_ready cyc=%0d got=%b exp=%b", cyc, bus.ready, exp_rdy); end
    end
    vectors++;
    if (bus.relock_cnt !== 8'd0) begin miscompares++; $display("FAIL clean_relock_cnt got=%0d exp=0", bus.relock_cnt); end
  endtask

  task automatic test_no_lock();
    logic exp_pll;
    logic exp_lf;
    apply_reset(1'b0);
    for (int e = 1; e <= 100; e++) begin
      tick();
      exp_pll = ((e % 24) < 4);
      exp_lf  = (e >= 72);
      vectors += 3;
      if (bus.pll_rst !== exp_pll) begin miscompares++; $display("FAIL nolock_pll_rst cyc=%0d got=%b exp=%b", cyc, bus.pll_rst, exp_pll); end
      if (bus.lock_fail !== exp_lf) begin miscompares++; $display("FAIL nolock_lock_fail cyc=%0d got=%b exp=%b", cyc, bus.lock_fail, exp_lf); end
      if (bus.sys_rst_n !== 4'b0000) begin miscompares++; $display("FAIL nolock_sys_rst_n cyc=%0d got=%b exp=0000", cyc, bus.sys_rst_n); end
    end
  endtask

  task automatic test_lock_loss();
    apply_reset(1'b1);
    run_to(22);
    bus.pll_locked = 1'b0;
    run_to(24);
    vectors += 3;
    if (bus.sys_rst_n !== 4'b1111) begin miscompares++; $display("FAIL loss_pre_sys cyc=%0d got=%b exp=1111", cyc, bus.sys_rst_n); end
    if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL loss_pre_ready cyc=%0d got=%b exp=1", cyc, bus.ready); end
    if (bus.relock_cnt !== 8'd0) begin miscompares++; $display("FAIL loss_pre_relock cyc=%0d got=%0d exp=0", cyc, bus.relock_cnt); end
    run_to(25);
    vectors += 4;
    if (bus.sys_rst_n !== 4'b0000) begin miscompares++; $display("FAIL loss_sys cyc=%0d got=%b exp=0000", cyc, bus.sys_rst_n); end
    if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL loss_ready cyc=%0d got=%b exp=0", cyc, bus.ready); end
    if (bus.relock_cnt !== 8'd1) begin miscompares++; $display("FAIL loss_relock cyc=%0d got=%0d exp=1", cyc, bus.relock_cnt); end
    if (bus.pll_rst !== 1'b1) begin miscompares++; $display("FAIL loss_pll_rst cyc=%0d got=%b exp=1", cyc, bus.pll_rst); end
    run_to(26);
    bus.pll_locked = 1'b1;
    run_to(28);
    vectors++;
    if (bus.pll_rst !== 1'b1) begin miscompares++; $display("FAIL loss_pll_hi cyc=%0d got=%b exp=1", cyc, bus.pll_rst); end
    run_to(29);
    vectors++;
    if (bus.pll_rst !== 1'b0) begin miscompares++; $display("FAIL loss_pll_lo cyc=%0d got=%b exp=0", cyc, bus.pll_rst); end
    run_to(38);
    vectors++;
    if (bus.sys_rst_n !== 4'b0000) begin miscompares++; $display("FAIL loss_rec_hold cyc=%0d got=%b exp=0000", cyc, bus.sys_rst_n); end
    run_to(39);
    vectors++;
    if (bus.sys_rst_n !== 4'b0001) begin miscompares++; $display("FAIL loss_rec_s0 cyc=%0d got=%b exp=0001", cyc, bus.sys_rst_n); end
    run_to(45);
    vectors += 2;
    if (bus.sys_rst_n !== 4'b1111) begin miscompares++; $display("FAIL loss_rec_s3 cyc=%0d got=%b exp=1111", cyc, bus.sys_rst_n); end
    if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL loss_rec_rdy_early cyc=%0d got=%b exp=0", cyc, bus.ready); end
    run_to(46);
    vectors += 2;
    if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL loss_rec_ready cyc=%0d got=%b exp=1", cyc, bus.ready); end
    if (bus.relock_cnt !== 8'd1) begin miscompares++; $display("FAIL loss_rec_relock cyc=%0d got=%0d exp=1", cyc, bus.relock_cnt); end
    // Lock loss and forced relock seen on the same edge: counted as a loss.
    run_to(47);
    bus.pll_locked = 1'b0;
    run_to(49);
    bus.force_relock = 1'b1;
    vectors++;
    if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL both_pre_ready cyc=%0d got=%b exp=1", cyc, bus.ready); end
    run_to(50);
    bus.force_relock = 1'b0;
    vectors += 3;
    if (bus.sys_rst_n !== 4'b0000) begin miscompares++; $display("FAIL both_sys cyc=%0d got=%b exp=0000", cyc, bus.sys_rst_n); end
    if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL both_ready cyc=%0d got=%b exp=0", cyc, bus.ready); end
    if (bus.relock_cnt !== 8'd2) begin miscompares++; $display("FAIL both_relock cyc=%0d got=%0d exp=2", cyc, bus.relock_cnt); end
  endtask

  task automatic test_force_relock();
    logic [7:0] exp_rc;
    apply_reset(1'b1);
    run_to(22);
    bus.force_relock = 1'b1;
    vectors += 2;
    if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL force_pre_ready cyc=%0d got=%b exp=1", cyc, bus.ready); end
    if (bus.sys_rst_n !== 4'b1111) begin miscompares++; $display("FAIL force_pre_sys cyc=%0d got=%b exp=1111", cyc, bus.sys_rst_n); end
    run_to(23);
    bus.force_relock = 1'b0;
    vectors += 4;
    if (bus.sys_rst_n !== 4'b0000) begin miscompares++; $display("FAIL force_sys cyc=%0d got=%b exp=0000", cyc, bus.sys_rst_n); end
    if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL force_ready cyc=%0d got=%b exp=0", cyc, bus.ready); end
    if (bus.pll_rst !== 1'b1) begin miscompares++; $display("FAIL force_pll_rst cyc=%0d got=%b exp=1", cyc, bus.pll_rst); end
    if (bus.relock_cnt !== 8'd0) begin miscompares++; $display("FAIL force_relock_cnt cyc=%0d got=%0d exp=0", cyc, bus.relock_cnt); end
    // A request during HOLDOFF must not restart anything.
    run_to(30);
    bus.force_relock = 1'b1;
    run_to(31);
    bus.force_relock = 1'b0;
    vectors++;
    if (bus.pll_rst !== 1'b0) begin miscompares++; $display("FAIL force_ignored_pll cyc=%0d got=%b exp=0", cyc, bus.pll_rst); end
    run_to(37);
    vectors++;
    if (bus.sys_rst_n !== 4'b0001) begin miscompares++; $display("FAIL force_rec_s0 cyc=%0d got=%b exp=0001", cyc, bus.sys_rst_n); end
    run_to(44);
    vectors++;
    if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL force_rec_ready cyc=%0d got=%b exp=1", cyc, bus.ready); end
    // Repeated lock losses drive relock_cnt into saturation.
    for (int i = 0; i < 256; i++) begin
      bus.pll_locked = 1'b0;
      repeat (3) tick();
      bus.pll_locked = 1'b1;
      exp_rc = (i >= 254) ? 8'd255 : 8'(i + 1);
      vectors++;
      if (bus.relock_cnt !== exp_rc) begin miscompares++; $display("FAIL sat_relock iter=%0d got=%0d exp=%0d", i, bus.relock_cnt, exp_rc); end
      repeat (22) tick();
      vectors++;
      if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL sat_ready iter=%0d got=%b exp=1", i, bus.ready); end
    end
  endtask

  task automatic test_holdoff_glitch();
    apply_reset(1'b0);
    run_to(52);
    bus.pll_locked = 1'b1;
    run_to(57);
    bus.pll_locked = 1'b0;
    run_to(58);
    bus.pll_locked = 1'b1;
    run_to(64);
    vectors++;
    if (bus.sys_rst_n !== 4'b0000) begin miscompares++; $display("FAIL glitch_early cyc=%0d got=%b exp=0000", cyc, bus.sys_rst_n); end
    run_to(69);
    vectors++;
    if (bus.sys_rst_n !== 4'b0000) begin miscompares++; $display("FAIL glitch_hold cyc=%0d got=%b exp=0000", cyc, bus.sys_rst_n); end
    run_to(70);
    vectors += 2;
    if (bus.sys_rst_n !== 4'b0001) begin miscompares++; $display("FAIL glitch_s0 cyc=%0d got=%b exp=0001", cyc, bus.sys_rst_n); end
    if (bus.lock_fail !== 1'b0) begin miscompares++; $display("FAIL glitch_lock_fail cyc=%0d got=%b exp=0", cyc, bus.lock_fail); end
    run_to(77);
    vectors++;
    if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL glitch_ready cyc=%0d got=%b exp=1", cyc, bus.ready); end
    // Retry count must have cleared on RUN: three fresh timeouts needed.
    bus.pll_locked = 1'b0;
    run_to(80);
    vectors += 2;
    if (bus.relock_cnt !== 8'd1) begin miscompares++; $display("FAIL glitch_relock cyc=%0d got=%0d exp=1", cyc, bus.relock_cnt); end
    if (bus.sys_rst_n !== 4'b0000) begin miscompares++; $display("FAIL glitch_abort_sys cyc=%0d got=%b exp=0000", cyc, bus.sys_rst_n); end
    run_to(104);
    vectors += 2;
    if (bus.pll_rst !== 1'b1) begin miscompares++; $display("FAIL retry_t1_pll cyc=%0d got=%b exp=1", cyc, bus.pll_rst); end
    if (bus.lock_fail !== 1'b0) begin miscompares++; $display("FAIL retry_t1_lf cyc=%0d got=%b exp=0", cyc, bus.lock_fail); end
    run_to(151);
    vectors++;
    if (bus.lock_fail !== 1'b0) begin miscompares++; $display("FAIL retry_t2_lf cyc=%0d got=%b exp=0", cyc, bus.lock_fail); end
    run_to(152);
    vectors++;
    if (bus.lock_fail !== 1'b1) begin miscompares++; $display("FAIL retry_t3_lf cyc=%0d got=%b exp=1", cyc, bus.lock_fail); end
  endtask

  // Continues from the end state of test_holdoff_glitch (lock_fail=1, relock_cnt=1).
  task automatic test_reset_mid_release();
    bus.pll_locked = 1'b1;
    run_to(168);
    vectors += 3;
    if (bus.sys_rst_n !== 4'b0011) begin miscompares++; $display("FAIL mid_pre_sys cyc=%0d got=%b exp=0011", cyc, bus.sys_rst_n); end
    if (bus.lock_fail !== 1'b1) begin miscompares++; $display("FAIL mid_pre_lf cyc=%0d got=%b exp=1", cyc, bus.lock_fail); end
    if (bus.relock_cnt !== 8'd1) begin miscompares++; $display("FAIL mid_pre_relock cyc=%0d got=%0d exp=1", cyc, bus.relock_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors += 5;
    if (bus.pll_rst !== 1'b1) begin miscompares++; $display("FAIL mid_pll_rst got=%b exp=1", bus.pll_rst); end
    if (bus.sys_rst_n !== 4'b0000) begin miscompares++; $display("FAIL mid_sys got=%b exp=0000", bus.sys_rst_n); end
    if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL mid_ready got=%b exp=0", bus.ready); end
    if (bus.relock_cnt !== 8'd0) begin miscompares++; $display("FAIL mid_relock got=%0d exp=0", bus.relock_cnt); end
    if (bus.lock_fail !== 1'b0) begin miscompares++; $display("FAIL mid_lock_fail got=%b exp=0", bus.lock_fail); end
    repeat (2) @(posedge refclk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    cyc              = 0;
    rst_n            = 1'b0;
    bus.pll_locked   = 1'b0;
    bus.force_relock = 1'b0;
    test_reset();
    test_clean_start();
    test_no_lock();
    test_lock_loss();
    test_force_relock();
    test_holdoff_glitch();
    test_reset_mid_release();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpc_rst_seq.md
# cpc_rst_seq

Reset/lock supervisor at the consuming end of the CPC clock PLL: it drives the PLL reset, watches the PLL lock indication, and releases the design's reset domains in a fixed order only after lock is stable. It runs on the 50 MHz board reference clock and sits between the board reset and every block clocked from the PLL's 48/16/4/1 MHz outputs. On lock loss it re-asserts all domain resets and restarts the PLL.

## Interface
- PLL_RST_CYCLES, 16: width of each `pll_rst` pulse, in refclk cycles.
- LOCK_TIMEOUT, 50000: cycles to wait for lock before re-pulsing the PLL (1 ms).
- HOLDOFF_CYCLES, 1024: consecutive synchronized-lock cycles required before the first release.
- STAGE_GAP, 64: cycles between successive stage releases.
- MAX_RETRIES, 8: consecutive lock timeouts before `lock_fail` sets.
- refclk  in  1  50 MHz reference clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL lock flag; asynchronous to refclk.
- force_relock  in  1  refclk-synchronous one-cycle request to restart the PLL.
- pll_rst  out  1  active-high reset to the PLL.
- sys_rst_n  out  4  active-low domain resets; bit k serves stage k (0=48 MHz, 1=16 MHz, 2=4 MHz, 3=1 MHz).
- ready  out  1  high only while all stages are released.
- relock_cnt  out  8  count of lock losses after release; saturates at 255.
- lock_fail  out  1  sticky flag: MAX_RETRIES consecutive timeouts occurred.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `locked_s`. All logic uses `locked_s`.
- FSM states: PLL_RST, WAIT_LOCK, HOLDOFF, RELEASE, RUN. One shared cycle counter is cleared on every state entry.
- **PLL_RST:** `pll_rst`=1. After PLL_RST_CYCLES cycles, go to WAIT_LOCK.
- **WAIT_LOCK:** `pll_rst`=0.
  - `locked_s`=1 → HOLDOFF.
  - Counter reaches LOCK_TIMEOUT-1 without lock → increment the retry counter, then go to PLL_RST.
  - When the retry counter reaches MAX_RETRIES, set `lock_fail`. Retrying continues after that.
- **HOLDOFF:**
  - Any cycle with `locked_s`=0 → WAIT_LOCK. The timeout restarts; no retry is counted.
  - HOLDOFF_CYCLES consecutive cycles with `locked_s`=1 → RELEASE.
- **RELEASE:** `sys_rst_n[k]` rises when counter == k*STAGE_GAP, for k=0..3. Once bit 3 is set, go to RUN.
- **RUN:** `ready`=1, and the retry counter clears on entry.
- **Abort** (RELEASE or RUN only), triggered by `locked_s`=0 or `force_relock`=1:
  - Next edge: `sys_rst_n`=0, `ready`=0, state PLL_RST.
  - `relock_cnt` increments only for lock loss, saturating at 255. A forced relock does not count.
- If both abort causes occur in the same cycle, it counts as a lock loss.
- `force_relock` is ignored outside RELEASE and RUN.
- Only `rst_n` clears `lock_fail` and `relock_cnt`.

## Timing
- Reset values while `rst_n`=0, applied asynchronously:
  - `pll_rst`=1, `sys_rst_n`=4'b0000, `ready`=0
  - `relock_cnt`=0, `lock_fail`=0
  - state PLL_RST, counters 0, synchronizer flops 0
- All outputs are registered and change only on the refclk rising edge.
- `pll_rst` is high for exactly PLL_RST_CYCLES cycles per pulse; it is also high while `rst_n` is asserted.
- Lock detect latency: 2 cycles (synchronizer) plus 1 cycle (FSM) from a `pll_locked` rise to the HOLDOFF entry.
- First release: `sys_rst_n[0]` rises HOLDOFF_CYCLES+1 cycles after HOLDOFF entry.
- Stages rise STAGE_GAP cycles apart. `ready` rises one cycle after `sys_rst_n[3]`.
- Abort latency: `sys_rst_n`/`ready` fall 3 cycles after a `pll_locked` fall, or 1 cycle after `force_relock`.
- Resets never release out of order. `sys_rst_n` never has a 0 bit above a 1 bit.

## Structure
- Package `cpc_rst_pkg`: FSM state enum, `NUM_STAGES`=4, and the stage-index constants.
- Sub-module `cpc_sync2`: a generic 2-flop synchronizer with async active-low reset, reused by the clock-crossing logic elsewhere.
- Counter width is derived from the largest of LOCK_TIMEOUT, HOLDOFF_CYCLES and 3*STAGE_GAP+1.
- `relock_cnt` saturating arithmetic: hold at 8'hFF.

## Test plan
All tests use PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, HOLDOFF_CYCLES=8, STAGE_GAP=2, MAX_RETRIES=3.
- **Clean start:** release `rst_n` with `pll_locked`=1 → `pll_rst` high exactly 4 cycles; `sys_rst_n` steps 0001, 0011, 0111, 1111 two cycles apart; `ready`=1 one cycle after 1111; `relock_cnt`=0.
- **No lock:** `pll_locked`=0 permanently → `pll_rst` pulses 4 high every 24 cycles; `lock_fail` sets on the 3rd timeout and stays set; `sys_rst_n` stays 0.
- **Holdoff glitch:** lock held for 5 cycles, low for 1, then high → no stage released until 8 uninterrupted cycles after the restart; retry counter unchanged.
- **Lock loss in RUN:** drop `pll_locked` → 3 cycles later `sys_rst_n`=0000, `ready`=0, `relock_cnt`=1, and `pll_rst` pulses; the full sequence then recovers.
- **Forced relock:** pulse `force_relock` in RUN → outputs drop 1 cycle later; `relock_cnt` unchanged. After 256 lock losses, `relock_cnt`=255.
- **Reset mid-release:** assert `rst_n` while `sys_rst_n`=0011 → all outputs take their reset values with no clock edge; `lock_fail`/`relock_cnt` clear.
